// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control, inserts
// load-use bubbles, precomputes EX forwarding selects and honours flush/hold.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_da,
  input  logic [XLEN-1:0]  id_db,
  input  logic [3:0]       id_alu_op,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             flush,
  input  logic             ex_hold,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  output logic             id_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_da,
  output logic [XLEN-1:0]  ex_db,
  output logic [3:0]       ex_alu_op,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [1:0]       ex_fwd_a,
  output logic [1:0]       ex_fwd_b,
  output logic [CNT_W-1:0] lu_count
);

  logic       lu;
  logic       advance;
  logic       bubble;
  logic [1:0] fwd_a_nx;
  logic [1:0] fwd_b_nx;

  // EX/MEM producer (the instruction now in EX) beats the older MEM/WB one.
  function automatic logic [1:0] fwd_sel(input logic use_s, input logic [4:0] rs,
                                         input logic ex_v, input logic ex_rw,
                                         input logic [4:0] exrd, input logic mem_rw,
                                         input logic [4:0] memrd);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_s && ex_v && ex_rw && exrd != 5'd0 && rs == exrd)
      sel = 2'b01;
    else if (use_s && mem_rw && memrd != 5'd0 && rs == memrd)
      sel = 2'b10;
    return sel;
  endfunction

  always_comb begin
    lu = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    id_stall = ex_hold || (lu && !flush);
    advance  = flush || !ex_hold;
    bubble   = flush || lu || !id_valid;
    fwd_a_nx = fwd_sel(id_use_rs1, id_rs1, ex_valid, ex_reg_write, ex_rd,
                       mem_reg_write, mem_rd);
    fwd_b_nx = fwd_sel(id_use_rs2, id_rs2, ex_valid, ex_reg_write, ex_rd,
                       mem_reg_write, mem_rd);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_imm       <= '0;
      ex_da        <= '0;
      ex_db        <= '0;
      ex_alu_op    <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_fwd_a     <= '0;
      ex_fwd_b     <= '0;
    end else if (advance) begin
      if (bubble) begin
        ex_valid     <= 1'b0;
        ex_pc        <= '0;
        ex_rs1       <= '0;
        ex_rs2       <= '0;
        ex_rd        <= '0;
        ex_imm       <= '0;
        ex_da        <= '0;
        ex_db        <= '0;
        ex_alu_op    <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_fwd_a     <= '0;
        ex_fwd_b     <= '0;
      end else begin
        ex_valid     <= 1'b1;
        ex_pc        <= id_pc;
        ex_rs1       <= id_rs1;
        ex_rs2       <= id_rs2;
        ex_rd        <= id_rd;
        ex_imm       <= id_imm;
        ex_da        <= id_da;
        ex_db        <= id_db;
        ex_alu_op    <= id_alu_op;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
        ex_mem_write <= id_mem_write;
        ex_fwd_a     <= fwd_a_nx;
        ex_fwd_b     <= fwd_b_nx;
      end
    end
  end

  // Only a bubble actually caused by load-use counts; flush and hold suppress it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lu_count <= '0;
    else if (!flush && !ex_hold && lu && lu_count != {CNT_W{1'b1}})
      lu_count <= lu_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes hand-computed expectations,
// a monitor pops them and checks id_stall before the edge and ex_* after it.
module tb_id_ex_stage;

  localparam int CAP  = 0;
  localparam int BUB  = 1;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs1, id_use_rs2;
  logic [31:0] id_pc, id_imm, id_da, id_db;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush, ex_hold, mem_reg_write;
  logic        id_stall, ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_da, ex_db;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [1:0]  ex_fwd_a, ex_fwd_b;
  logic [1:0]  lu_count;

  typedef struct {
    string       name;
    logic        stall;
    logic        valid;
    logic [31:0] pc, imm, da, db;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        rw, mr, mw;
    logic [1:0]  fa, fb;
    logic [1:0]  cnt;
  } exp_t;

  exp_t expQ[$];
  exp_t lastExp;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   satSeq[5] = '{1, 2, 3, 3, 3};

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_imm(id_imm), .id_da(id_da), .id_db(id_db), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush), .ex_hold(ex_hold), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_da(ex_da), .ex_db(ex_db),
    .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .lu_count(lu_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [31:0] got,
                     input logic [31:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s.%s got %h expected %h", nm, fld, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.name, "ex_valid", ex_valid, e.valid);
    cmp(e.name, "ex_pc", ex_pc, e.pc);
    cmp(e.name, "ex_rs1", ex_rs1, e.rs1);
    cmp(e.name, "ex_rs2", ex_rs2, e.rs2);
    cmp(e.name, "ex_rd", ex_rd, e.rd);
    cmp(e.name, "ex_imm", ex_imm, e.imm);
    cmp(e.name, "ex_da", ex_da, e.da);
    cmp(e.name, "ex_db", ex_db, e.db);
    cmp(e.name, "ex_alu_op", ex_alu_op, e.op);
    cmp(e.name, "ex_reg_write", ex_reg_write, e.rw);
    cmp(e.name, "ex_mem_read", ex_mem_read, e.mr);
    cmp(e.name, "ex_mem_write", ex_mem_write, e.mw);
    cmp(e.name, "ex_fwd_a", ex_fwd_a, e.fa);
    cmp(e.name, "ex_fwd_b", ex_fwd_b, e.fb);
    cmp(e.name, "lu_count", lu_count, e.cnt);
  endtask

  function automatic exp_t zeroExp(input string nm);
    exp_t e;
    e.name = nm; e.stall = 1'b0; e.valid = 1'b0;
    e.pc = '0; e.imm = '0; e.da = '0; e.db = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.op = '0;
    e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
    e.fa = '0; e.fb = '0; e.cnt = '0;
    return e;
  endfunction

  // Operand/immediate values are derived from pc and rd so each capture is distinct.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic fl, input logic hold, input logic [4:0] mrd,
                               input logic mrw);
    @(posedge clk); #1;
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = rd;
    id_imm = {pc[15:0], 11'd0, rd};
    id_da = pc ^ 32'hDEAD_0000;
    id_db = ~pc;
    id_alu_op = rd[3:0] ^ 4'h5;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = rd[0];
    flush = fl; ex_hold = hold; mem_rd = mrd; mem_reg_write = mrw;
  endtask

  task automatic expectCycle(input string nm, input int kind, input logic [1:0] fa,
                             input logic [1:0] fb, input logic [1:0] cnt, input logic stall);
    exp_t e;
    if (kind == CAP) begin
      e = zeroExp(nm);
      e.valid = 1'b1; e.pc = id_pc; e.rs1 = id_rs1; e.rs2 = id_rs2; e.rd = id_rd;
      e.imm = id_imm; e.da = id_da; e.db = id_db; e.op = id_alu_op;
      e.rw = id_reg_write; e.mr = id_mem_read; e.mw = id_mem_write;
      e.fa = fa; e.fb = fb;
    end else if (kind == HOLD) begin
      e = lastExp;
      e.name = nm;
    end else begin
      e = zeroExp(nm);
    end
    e.cnt = cnt;
    e.stall = stall;
    lastExp = e;
    expQ.push_back(e);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (expQ.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #3;
    cmp(nm, "queue_left", expQ.size(), 0);
  endtask

  task automatic checkZero(input string nm);
    exp_t e;
    e = zeroExp(nm);
    checkOutput(e);
    cmp(nm, "id_stall", id_stall, ex_hold);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        cmp(e.name, "id_stall", id_stall, e.stall);
        @(posedge clk); #1;
        checkOutput(e);
      end
    end
  end

  initial begin
    lastExp = zeroExp("init");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      id_valid = 1'($urandom); id_pc = $urandom; id_rs1 = 5'($urandom);
      id_rs2 = 5'($urandom); id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      id_rd = 5'($urandom); id_imm = $urandom; id_da = $urandom; id_db = $urandom;
      id_alu_op = 4'($urandom); id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
      id_mem_write = 1'($urandom); flush = 1'($urandom); ex_hold = 1'($urandom);
      mem_rd = 5'($urandom); mem_reg_write = 1'($urandom);
      @(posedge clk); #1;
      checkZero("reset_random");
    end
    @(negedge clk);
    id_valid = 1'b0; flush = 1'b0; ex_hold = 1'b0; mem_reg_write = 1'b0;
    reset = 1'b1;

    applyStimulus(1, 32'h100, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0);
    expectCycle("first_cap", CAP, 2'b00, 2'b00, 0, 0);
    applyStimulus(1, 32'h104, 5, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0);
    expectCycle("load_cap", CAP, 2'b01, 2'b00, 0, 0);
    applyStimulus(1, 32'h108, 7, 1, 1, 1, 8, 1, 0, 0, 0, 5, 1);
    expectCycle("lu_bubble", BUB, 2'b00, 2'b00, 1, 1);
    applyStimulus(1, 32'h108, 7, 1, 1, 1, 8, 1, 0, 0, 0, 7, 1);
    expectCycle("lu_recap", CAP, 2'b10, 2'b00, 1, 0);
    applyStimulus(1, 32'h10C, 8, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0);
    expectCycle("alu_rd3", CAP, 2'b01, 2'b00, 1, 0);
    applyStimulus(1, 32'h110, 3, 3, 1, 1, 0, 1, 0, 0, 0, 3, 1);
    expectCycle("fwd_prio", CAP, 2'b01, 2'b01, 1, 0);
    applyStimulus(1, 32'h114, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 1);
    expectCycle("fwd_x0", CAP, 2'b00, 2'b00, 1, 0);
    applyStimulus(1, 32'h118, 0, 0, 1, 1, 10, 1, 0, 0, 0, 0, 0);
    expectCycle("x0_load", CAP, 2'b00, 2'b00, 1, 0);
    applyStimulus(1, 32'h200, 10, 10, 1, 1, 11, 1, 0, 0, 1, 0, 0);
    expectCycle("hold1", HOLD, 2'b00, 2'b00, 1, 1);
    applyStimulus(1, 32'h204, 11, 12, 1, 1, 12, 0, 1, 0, 1, 0, 0);
    expectCycle("hold2", HOLD, 2'b00, 2'b00, 1, 1);
    applyStimulus(1, 32'h208, 4, 5, 1, 0, 13, 1, 0, 0, 1, 0, 0);
    expectCycle("hold3", HOLD, 2'b00, 2'b00, 1, 1);
    applyStimulus(1, 32'h20C, 10, 2, 1, 1, 14, 1, 0, 0, 0, 0, 0);
    expectCycle("hold_release", CAP, 2'b01, 2'b00, 1, 0);
    applyStimulus(1, 32'h210, 1, 2, 1, 0, 12, 1, 1, 0, 0, 0, 0);
    expectCycle("load12", CAP, 2'b00, 2'b00, 1, 0);
    applyStimulus(1, 32'h214, 12, 3, 1, 1, 15, 1, 0, 1, 1, 0, 0);
    expectCycle("flush_lu_hold", BUB, 2'b00, 2'b00, 1, 1);
    applyStimulus(1, 32'h218, 1, 2, 1, 0, 12, 1, 1, 0, 0, 0, 0);
    expectCycle("load12b", CAP, 2'b00, 2'b00, 1, 0);
    applyStimulus(1, 32'h21C, 12, 3, 1, 1, 15, 1, 0, 1, 0, 0, 0);
    expectCycle("flush_lu", BUB, 2'b00, 2'b00, 1, 0);
    applyStimulus(0, 32'h300, 2, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0);
    expectCycle("idle_bubble", BUB, 2'b00, 2'b00, 1, 0);
    applyStimulus(1, 32'h304, 2, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0);
    expectCycle("pre_reset", CAP, 2'b00, 2'b00, 1, 0);
    drain("drain_main");

    // Asynchronous reset mid-cycle, away from any clock edge.
    reset = 1'b0;
    #1;
    checkZero("async_reset");
    @(negedge clk);
    id_valid = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 32'h400 + 32'(16 * i), 1, 2, 1, 0, 6, 1, 1, 0, 0, 0, 0);
      expectCycle("sat_load", CAP, 2'b00, 2'b00, (i == 0) ? 2'd0 : 2'(satSeq[i-1]), 0);
      applyStimulus(1, 32'h404 + 32'(16 * i), 6, 2, 1, 1, 9, 1, 0, 0, 0, 0, 0);
      expectCycle("sat_lu", BUB, 2'b00, 2'b00, 2'(satSeq[i]), 1);
    end
    applyStimulus(1, 32'h500, 6, 2, 1, 1, 9, 1, 0, 0, 0, 6, 1);
    expectCycle("sat_recap", CAP, 2'b10, 2'b00, 3, 0);
    drain("drain_sat");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the 5-stage RISC-V core. Sits between decode (which reads `register_file`) and the ALU. It captures decoded operands and control, detects load-use hazards, and inserts bubbles. It also precomputes EX-stage forwarding selects and honours flush/hold from the back end.

## Interface
Parameters:
- XLEN, 32, data/PC/immediate width
- CNT_W, 16, width of the load-use bubble counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2  in  5  source register indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads that source
- id_rd  in  5  destination index
- id_imm  in  XLEN  decoded immediate
- id_da, id_db  in  XLEN  register file read data, already WB-bypassed
- id_alu_op  in  4  ALU operation code
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- flush  in  1  branch/jump redirect from EX; kill the instruction entering EX
- ex_hold  in  1  back end busy; EX, EX/MEM and MEM/WB all freeze this cycle
- mem_rd  in  5  rd of instruction currently in EX/MEM
- mem_reg_write  in  1  that instruction writes a register
- id_stall  out  1  combinational; decode/fetch must hold this cycle
- ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_da, ex_db, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write  out  (same widths as id_*)  registered EX-stage fields
- ex_fwd_a, ex_fwd_b  out  2  operand source: 00 = ex_da/ex_db, 01 = EX/MEM result, 10 = MEM/WB result
- lu_count  out  CNT_W  saturating count of load-use bubbles inserted

## Operation
- Load-use condition `lu`: id_valid & ex_valid & ex_mem_read & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- id_stall = ex_hold | (lu & ~flush).
- Per-edge action, in priority order:
  1. flush=1: insert a bubble. Flush wins over ex_hold and lu.
  2. ex_hold=1: every ex_* output and lu_count keep their value.
  3. lu=1: insert a bubble and increment lu_count. Decode holds, so the same instruction is presented again next cycle.
  4. Otherwise, capture all id_* fields into ex_*, with ex_valid=id_valid.
- Bubble: ex_valid, ex_reg_write, ex_mem_read and ex_mem_write are 0. All other ex_* fields, including fwd selects, are cleared to 0.
- When id_valid=0, the capture is treated as a bubble: fields are zeroed, and lu_count does not change.
- Forward select for source s (rs1→ex_fwd_a, rs2→ex_fwd_b), computed from current state at capture:
  - 01 if id_use_s, ex_valid, ex_reg_write, ex_rd≠0 and id_rs_s==ex_rd.
  - Else 10 if id_use_s, mem_reg_write, mem_rd≠0 and id_rs_s==mem_rd.
  - Else 00. Priority 01 > 10.
- After a load-use bubble, the load has moved to EX/MEM, so recapturing the dependent instruction yields select 10 (load data from MEM/WB).
- lu_count saturates at 2^CNT_W−1 and never wraps.

## Timing
- Latency: one cycle from id_* to ex_*.
- id_stall is combinational from current ex_* state plus id_*/flush/ex_hold. It has no path from ex_* next-state.
- Reset low: all outputs go to 0 asynchronously, including lu_count. The first capture happens on the first rising edge after reset deasserts. Reset mid-hold or mid-stall discards all state.
- A load-use stall lasts exactly one cycle per load. On the following edge lu is false because ex_valid=0.
- flush and lu in the same cycle: bubble inserted, lu_count unchanged, id_stall=0.
- flush and ex_hold in the same cycle: bubble inserted, id_stall=1.
- A load with rd=x0 never stalls and never produces a forward select.

## Test plan
- Reset: hold reset low with random inputs → all ex_* = 0, lu_count=0. Release, then id_valid=1, id_pc=0x100, id_rd=5 → next edge ex_pc=0x100, ex_rd=5, ex_valid=1.
- Load-use: EX holds a load (rd=7, mem_read), ID presents add x8,x7,x1 → id_stall=1 for one cycle, bubble in EX, lu_count=1. With mem_rd=7 and mem_reg_write=1, the next capture gives ex_fwd_a=10.
- Forwarding priority: EX holds an ALU op rd=3, mem_rd=3 with mem_reg_write=1, ID reads rs1=3,rs2=3 → ex_fwd_a=01, ex_fwd_b=01. Repeat with rd=0 → both 00.
- Hold: ex_hold=1 for 3 cycles with changing id_* → ex_* stable and id_stall=1 throughout. Release → captures the id_* present on the release edge.
- Flush priority: flush=1 together with lu=1 and ex_hold=1 → ex_valid=0, control bits 0, lu_count unchanged.
- Saturation: CNT_W=2, force 5 load-use events → lu_count sequence 1,2,3,3,3.
